// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared defaults, the mode encoding and the read-latency bound
//                for the memory responder and its read pipeline.
//  Contents    : ADDR_W_DEF, DATA_W_DEF  - default address / data widths
//                MAX_READ_LAT            - largest supported read latency
//                mode_e                  - MODE_CORE / MODE_LOAD
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_READ_LAT = 7;

    typedef enum logic [0:0] {
        MODE_CORE = 1'b0,
        MODE_LOAD = 1'b1
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_pipe
//  Description : STAGES-deep valid / out-of-range shift register tracking
//                reads in flight. The array index is captured in the first
//                stage only: the array is read from that stage, so later
//                stages never need the address again.
//  Ports       : clk        in  clock
//                rst        in  asynchronous active-high clear
//                flush_i    in  synchronous flush of every stage
//                valid_i    in  read issued this edge
//                addr_i     in  array index of the read
//                oob_i      in  read address is out of range
//                rd_addr_o  out stage-1 index (array read address)
//                valid_o    out last-stage valid
//                oob_o      out last-stage out-of-range flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_pipe #(
    parameter int ADDR_W = 10,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              oob_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              valid_o,
    output logic              oob_o
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] oob_q;
    logic [STAGES-1:0] oob_d;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        valid_d = '0;
        oob_d   = '0;
        if (!flush_i) begin
            valid_d[0] = valid_i;
            oob_d[0]   = oob_i;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                oob_d[k]   = oob_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            oob_q   <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            oob_q   <= oob_d;
            if (valid_i) begin
                addr_q <= addr_i;
            end
        end
    end

    assign rd_addr_o = addr_q;
    assign valid_o   = valid_q[STAGES-1];
    assign oob_o     = oob_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed memory responder for the multi-cycle core.
//                Reads return after READ_LAT edges (legal 1..MAX_READ_LAT),
//                writes commit on the sampling edge, and a loader port
//                preloads the array while the core is held off.
//  Ports       : clk, rst            clock, asynchronous active-high reset
//                en_i, ren_i, wen_i  core enable / read / write
//                addr_i, din_i       core word address / write data
//                dout_o, rd_valid_o  read data (held) / new-data pulse
//                busy_o              loader owns the array
//                load_en_i           loader mode request
//                load_we_i           loader write strobe
//                load_addr_i         loader word address
//                load_data_i         loader write data
//                load_ack_o          loader write acknowledge pulse
//                err_oob_o           sticky out-of-range access flag
//                err_proto_o         sticky read+write conflict flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              ren_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    input  logic              load_en_i,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ack_o,
    output logic              err_oob_o,
    output logic              err_proto_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    localparam logic [0:0] ST_CORE = MODE_CORE;
    localparam logic [0:0] ST_LOAD = MODE_LOAD;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] dout_q;
    logic              rd_valid_q;
    logic              ld_wr_q;
    logic              load_ack_q;
    logic              err_oob_q;
    logic              err_proto_q;

    logic              core_act;
    logic              core_rd;
    logic              core_wr;
    logic              core_oob;
    logic              ld_wr;
    logic              ld_oob;
    logic              enter_load;
    logic [IDX_W-1:0]  core_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              pipe_valid;
    logic              pipe_oob;
    logic [DATA_W-1:0] rdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign core_act   = (state_q == ST_CORE);
    assign core_wr    = core_act & en_i & wen_i;
    // A simultaneous write takes precedence, so no read is issued.
    assign core_rd    = core_act & en_i & ren_i & ~wen_i;
    assign core_oob   = ({1'b0, addr_i} >= DEPTH_X);
    assign ld_wr      = (state_q == ST_LOAD) & load_en_i & load_we_i;
    assign ld_oob     = ({1'b0, load_addr_i} >= DEPTH_X);
    assign enter_load = core_act & load_en_i;
    assign core_idx   = addr_i[IDX_W-1:0];
    assign ld_idx     = load_addr_i[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CORE) begin
            if (load_en_i) begin
                state_d = ST_LOAD;
            end
        end else begin
            if (!load_en_i) begin
                state_d = ST_CORE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: single write port shared by core and loader (the mode
    // makes them mutually exclusive); out-of-range writes are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (core_wr && !core_oob) begin
            mem_q[core_idx] <= din_i;
        end else if (ld_wr && !ld_oob) begin
            mem_q[ld_idx] <= load_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: one stage per cycle of latency.
    // ------------------------------------------------------------------
    mem_resp_pipe #(
        .ADDR_W (IDX_W),
        .STAGES (READ_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (enter_load),
        .valid_i   (core_rd),
        .addr_i    (core_idx),
        .oob_i     (core_oob),
        .rd_addr_o (rd_idx),
        .valid_o   (pipe_valid),
        .oob_o     (pipe_oob)
    );

    // The array is always read one edge after issue. With a latency of one
    // that read lands straight in dout; otherwise it is registered and then
    // delayed to line up with the last pipeline stage.
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rdata = mem_q[rd_idx];
        end else begin : g_latn
            logic [DATA_W-1:0] chain_q [2:READ_LAT];

            always_ff @(posedge clk) begin
                chain_q[2] <= mem_q[rd_idx];
                for (int k = 3; k <= READ_LAT; k++) begin
                    chain_q[k] <= chain_q[k-1];
                end
            end

            assign rdata = chain_q[READ_LAT];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CORE;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            ld_wr_q     <= 1'b0;
            load_ack_q  <= 1'b0;
            err_oob_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // A read completing on the edge that enters LOAD is flushed too.
            rd_valid_q <= pipe_valid & ~enter_load;
            if (pipe_valid && !enter_load) begin
                dout_q <= pipe_oob ? '0 : rdata;
            end
            ld_wr_q     <= ld_wr;
            load_ack_q  <= ld_wr_q;
            err_oob_q   <= err_oob_q | ((core_rd | core_wr) & core_oob)
                                     | (ld_wr & ld_oob);
            err_proto_q <= err_proto_q | (core_act & en_i & ren_i & wen_i);
        end
    end

    assign dout_o      = dout_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = (state_q == ST_LOAD);
    assign load_ack_o  = load_ack_q;
    assign err_oob_o   = err_oob_q;
    assign err_proto_o = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder (DEPTH=1024,
//                READ_LAT=3). Expected read data and arrival cycle are queued
//                when a read is driven and checked when rd_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int READ_LAT = 3;

    localparam int OP_IDLE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;
    localparam int OP_CONF = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, ren, wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_valid, busy;
    logic              load_en, load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ack, err_oob, err_proto;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int                op;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
        logic              eoob;
        logic              eproto;
    } vec_t;
    vec_t vecs[15];

    mem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .ren_i       (ren),
        .wen_i       (wen),
        .addr_i      (addr),
        .din_i       (din),
        .dout_o      (dout),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .load_en_i   (load_en),
        .load_we_i   (load_we),
        .load_addr_i (load_addr),
        .load_data_i (load_data),
        .load_ack_o  (load_ack),
        .err_oob_o   (err_oob),
        .err_proto_o (err_proto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and run the scoreboard against the outputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 dout=%h, expected no read (cycle %0d)",
                         dout, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rd_data", dout, e.data);
                check("rd_latency_cycle", DATA_W'(cyc), DATA_W'(e.due));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_rd_valid: got no rd_valid, expected data %h at cycle %0d", e.data, e.due);
        end
    endtask

    task automatic drive(input int op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp);
        en   = (op != OP_IDLE);
        ren  = (op == OP_RD) || (op == OP_CONF);
        wen  = (op == OP_WR) || (op == OP_CONF);
        addr = a;
        din  = d;
        if (op == OP_RD) sb_q.push_back('{exp, cyc + 1 + READ_LAT});
    endtask

    task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
        check("load_ack_same_edge", DATA_W'(load_ack), 0);
        tick();
        check("load_ack_next_edge", DATA_W'(load_ack), 1);
        tick();
        check("load_ack_pulse_end", DATA_W'(load_ack), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},      dout, 0);
        check({tag, "_rd_valid"},  DATA_W'(rd_valid), 0);
        check({tag, "_busy"},      DATA_W'(busy), 0);
        check({tag, "_load_ack"},  DATA_W'(load_ack), 0);
        check({tag, "_err_oob"},   DATA_W'(err_oob), 0);
        check({tag, "_err_proto"}, DATA_W'(err_proto), 0);
    endtask

    initial begin
        vecs[0]  = '{OP_RD,   16'h0005, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1]  = '{OP_RD,   16'h0000, 32'h0,        32'h00000011, 1'b0, 1'b0};
        vecs[2]  = '{OP_RD,   16'h0001, 32'h0,        32'h00000022, 1'b0, 1'b0};
        vecs[3]  = '{OP_RD,   16'h0002, 32'h0,        32'h00000033, 1'b0, 1'b0};
        vecs[4]  = '{OP_WR,   16'h0009, 32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{OP_RD,   16'h0009, 32'h0,        32'h12345678, 1'b0, 1'b0};
        vecs[6]  = '{OP_RD,   16'h0007, 32'h0,        32'h00000070, 1'b0, 1'b0};
        vecs[7]  = '{OP_WR,   16'h0007, 32'h00000099, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{OP_RD,   16'h0007, 32'h0,        32'h00000099, 1'b0, 1'b0};
        vecs[9]  = '{OP_RD,   16'h0400, 32'h0,        32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{OP_CONF, 16'h0004, 32'h000000A5, 32'h0,        1'b1, 1'b1};
        vecs[11] = '{OP_RD,   16'h0004, 32'h0,        32'h000000A5, 1'b1, 1'b1};
        vecs[12] = '{OP_WR,   16'hFFFF, 32'h0000CAFE, 32'h0,        1'b1, 1'b1};
        vecs[13] = '{OP_RD,   16'h03FF, 32'h0,        32'h00000077, 1'b1, 1'b1};
        vecs[14] = '{OP_IDLE, 16'h0000, 32'h0,        32'h0,        1'b1, 1'b1};

        rst = 1'b1; en = 0; ren = 0; wen = 0; addr = '0; din = '0;
        load_en = 0; load_we = 0; load_addr = '0; load_data = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Loader preload.
        load_en = 1'b1;
        tick();
        check("busy_in_load", DATA_W'(busy), 1);
        ld_write(16'h0005, 32'hDEADBEEF);
        ld_write(16'h0000, 32'h00000011);
        ld_write(16'h0001, 32'h00000022);
        ld_write(16'h0002, 32'h00000033);
        ld_write(16'h0007, 32'h00000070);
        ld_write(16'h0004, 32'h00000000);
        ld_write(16'h03FF, 32'h00000077);
        load_en = 1'b0;
        tick();
        check("busy_back_to_core", DATA_W'(busy), 0);

        // Core traffic, one operation per edge.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].exp);
            tick();
            check($sformatf("err_oob_row%0d", i),   DATA_W'(err_oob),   DATA_W'(vecs[i].eoob));
            check($sformatf("err_proto_row%0d", i), DATA_W'(err_proto), DATA_W'(vecs[i].eproto));
        end
        drive(OP_IDLE, '0, '0, '0);
        repeat (READ_LAT + 3) tick();
        check("scoreboard_drained", DATA_W'(sb_q.size()), 0);

        // A read in flight when LOAD is entered must be dropped.
        drive(OP_RD, 16'h0001, '0, '0);
        void'(sb_q.pop_back());
        tick();
        drive(OP_IDLE, '0, '0, '0);
        load_en = 1'b1;
        repeat (READ_LAT + 3) tick();
        check("busy_after_flush", DATA_W'(busy), 1);
        load_en = 1'b0;
        tick();

        // Reset asserted one edge after a read is issued.
        drive(OP_RD, 16'h0002, '0, '0);
        void'(sb_q.pop_back());
        tick();
        drive(OP_IDLE, '0, '0, '0);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_read_reset");
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Out-of-range write after reset: flag only, array untouched.
        drive(OP_WR, 16'hFFFF, 32'h0BADF00D, '0);
        tick();
        check("err_oob_write", DATA_W'(err_oob), 1);
        check("err_proto_after_reset", DATA_W'(err_proto), 0);
        drive(OP_RD, 16'h03FF, '0, 32'h00000077);
        tick();
        drive(OP_IDLE, '0, '0, '0);
        repeat (READ_LAT + 3) tick();
        check("final_scoreboard_drained", DATA_W'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle core's single-port memory interface. The core drives `en`/`ren`/`wen`/`addr`/`din` as the initiator and counts fixed wait states before sampling `dout`. This block is the other end of that interface: a word-addressed data/instruction store that returns read data at a fixed, parameterised latency and commits writes in one cycle. It also has a loader port that preloads the program image while the core is held off.

## Interface
Parameters:
- `ADDR_W`, 16: width of the word address.
- `DATA_W`, 32: data word width.
- `DEPTH`, 1024: number of implemented words. Valid addresses are 0..DEPTH-1.
- `READ_LAT`, 3: cycles from request sample to data valid. Legal range 1..7.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: core port enable.
- `ren`  in  1: core read request. Qualified by `en`.
- `wen`  in  1: core write request. Qualified by `en`.
- `addr`  in  ADDR_W: core word address.
- `din`  in  DATA_W: core write data.
- `dout`  out  DATA_W: read data. Held until the next read completes.
- `rd_valid`  out  1: one-cycle pulse when `dout` takes a new value.
- `busy`  out  1: high while the loader owns the array. Core requests are ignored.
- `load_en`  in  1: loader mode request.
- `load_we`  in  1: loader write strobe. Qualified by `load_en`.
- `load_addr`  in  ADDR_W: loader word address.
- `load_data`  in  DATA_W: loader write data.
- `load_ack`  out  1: one-cycle pulse, registered one cycle after an accepted loader write.
- `err_oob`  out  1: sticky flag. Set by any out-of-range access.
- `err_proto`  out  1: sticky flag. Set by `en & ren & wen` in the same cycle.

## Operation
State machine with states CORE and LOAD. Reset state is CORE.
- CORE → LOAD when `load_en`=1 is sampled.
- LOAD → CORE when `load_en`=0 is sampled.
- On entering LOAD, all in-flight read pipeline stages are flushed. No `rd_valid` is produced for those reads.

Behaviour in CORE, per sampling edge:
- **Read:** `en & ren & !wen` issues a read. `addr` enters a READ_LAT-deep valid/address pipeline.
  - Holding the request for several cycles issues one read per cycle. This is legal, and each read completes in order.
- **Write:** `en & wen` writes `din` to `mem[addr]` on that edge.
  - If `ren` is also high, the write wins, no read is issued, and `err_proto` is set.
- **Read-after-write:** a read issued on the edge after a write to the same address returns the new data.

Behaviour in LOAD:
- `busy`=1 and core inputs are ignored.
- `load_we` writes `load_data` to `mem[load_addr]` and produces `load_ack` on the next cycle.

Out-of-range accesses (`addr >= DEPTH`):
- A read completes normally with `dout` = 0.
- A write is dropped.
- Both set `err_oob`.

Reset:
- Reset values: `dout`=0, `rd_valid`=0, `busy`=0, `load_ack`=0, `err_oob`=0, `err_proto`=0. Pipeline valids are cleared.
- Array contents are not reset.
- Reset asserted mid-read cancels the read: no `rd_valid` is produced after reset deasserts.
- Only reset clears `err_oob` and `err_proto`.

## Timing
- **Read latency:** a read request sampled at edge N gives `rd_valid`=1 and the new `dout` after edge N+READ_LAT. With READ_LAT=3 this matches the core's three wait states exactly.
- **Read throughput:** one read per cycle. Pipeline stages are independent.
- **Write:** commits at the sampling edge, with zero added latency and no acknowledge on the core port.
- **Loader:** `load_ack` follows edge N (accepted write) after edge N+1.
- **Mode change:** takes effect one cycle after `load_en` is sampled. `busy` is registered and changes on that same edge.
- **Reads in flight during a write to the same address:** they return data read from the array at issue +1 edge. A write at issue +1 or later is therefore not visible to that read.

## Structure
- Package `mem_resp_pkg` holds:
  - the `ADDR_W` and `DATA_W` defaults;
  - the mode enum (`MODE_CORE`, `MODE_LOAD`);
  - the `MAX_READ_LAT` constant (7).
- Sub-module `mem_resp_pipe` is a READ_LAT-stage valid/address/out-of-range shift register with a synchronous flush and asynchronous clear.
- The array is inferred as a synchronous-read block RAM in the top module. `dout` is the final registered stage.

## Test plan
- **Load then read:** in LOAD, write 0xDEADBEEF to address 5 → `load_ack` pulses one cycle later. Return to CORE and read address 5 at edge N → `rd_valid` after N+3 and `dout`=0xDEADBEEF.
- **Back-to-back reads:** read addresses 0, 1, 2 on consecutive edges holding 0x11, 0x22, 0x33 → three consecutive `rd_valid` pulses with `dout` 0x11, 0x22, 0x33 in order.
- **Write then read:** write 0x12345678 to address 9, then read address 9 on the next edge → `dout`=0x12345678 after three further edges.
- **Conflicting request:** `en`=`ren`=`wen`=1 with address 4 and `din`=0xA5 → `mem[4]`=0xA5, no `rd_valid`, `err_proto`=1 and it stays set.
- **Out-of-range:** read address 0x0400 with DEPTH=1024 → `dout`=0 with `rd_valid`, and `err_oob`=1. A write to 0xFFFF leaves the array unchanged.
- **Reset mid-read:** issue a read, then assert `rst` one edge later → all outputs return to their reset values, and no `rd_valid` appears for 10 cycles after release.
